// File: rtl/alu_pkg.sv
// Purpose: shared ALU control codes, opcode/funct constants and decoded-beat control struct.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   // ALU operation codes understood by the downstream ALU
   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // funct3 / funct7 selectors
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Width-independent part of a decoded beat; operands are carried beside it
   // because their width follows the XLEN parameter of the instantiating module.
   typedef struct packed {
      logic [3:0] ctrl;
      logic [4:0] rd;
      logic       regWrite;
      logic       branch;
      logic       illegal;
   } aluCtrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Purpose: combinational decode of opcode/funct fields into ALU control code and operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
// Ports: opcode/funct3/funct7 + rs1Data/rs2Data/imm in; op1/op2/ctrl/regWrite/branch/illegal out.
module alu_op_decode
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] rs1Data,
   input  logic [XLEN-1:0] rs2Data,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [3:0]      ctrl,
   output logic            regWrite,
   output logic            branch,
   output logic            illegal
);

   always_comb begin
      op1      = rs1Data;
      op2      = '0;
      ctrl     = ALU_NOP;
      regWrite = 1'b0;
      branch   = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            op2      = rs2Data;
            regWrite = 1'b1;
            if (funct3 == F3_ADD && funct7 == F7_BASE)      ctrl = ALU_ADD;
            else if (funct3 == F3_ADD && funct7 == F7_ALT)  ctrl = ALU_SUB;
            else if (funct3 == F3_XOR && funct7 == F7_BASE) ctrl = ALU_XOR;
            else if (funct3 == F3_SRL && funct7 == F7_BASE) begin
               ctrl = ALU_SRL;
               // ALU shifts by the whole of operand B, so keep only the shamt bits
               op2  = {{(XLEN-5){1'b0}}, rs2Data[4:0]};
            end
            else illegal = 1'b1;
         end
         OP_ITYPE: begin
            op2      = imm;
            regWrite = 1'b1;
            if (funct3 == F3_ADD)      ctrl = ALU_ADD;
            else if (funct3 == F3_XOR) ctrl = ALU_XOR;
            else if (funct3 == F3_SRL && funct7 == F7_BASE) begin
               ctrl = ALU_SRL;
               op2  = {{(XLEN-5){1'b0}}, imm[4:0]};
            end
            else illegal = 1'b1;
         end
         OP_LOAD: begin
            op2      = imm;
            ctrl     = ALU_ADD;
            regWrite = 1'b1;
            illegal  = (funct3 != F3_WORD);
         end
         OP_STORE: begin
            op2     = imm;
            ctrl    = ALU_ADD;
            illegal = (funct3 != F3_WORD);
         end
         OP_BRANCH: begin
            op2     = rs2Data;
            ctrl    = ALU_SUB;
            branch  = 1'b1;
            illegal = (funct3 != F3_BEQ);
         end
         default: illegal = 1'b1;
      endcase
      // Unsupported beats still flow but must not disturb the ALU or register file
      if (illegal) begin
         op1      = '0;
         op2      = '0;
         ctrl     = ALU_NOP;
         regWrite = 1'b0;
         branch   = 1'b0;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Purpose: ID/EX issue stage: decodes a beat and presents registered ALU operands/control.
// Latency: 1 cycle from input accept to outValid; 1 beat/cycle sustained.
// Backpressure: 2-entry skid buffer; inReady (registered) drops only once the skid entry fills.
// Ports: clk/rst_n/flush; in* decoded-instruction beat with inValid/inReady;
//        aluInput1/2, aluControlAlu, outRd, outRegWrite, outBranch, outIllegal with outValid/outReady.
// Option: define ALU_ISSUE_STATS_EN to add saturating issueCount/illegalCount outputs.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32
`ifdef ALU_ISSUE_STATS_EN
   ,
   parameter int CNT_WIDTH = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [6:0]           inOpcode,
   input  logic [2:0]           inFunct3,
   input  logic [6:0]           inFunct7,
   input  logic [XLEN-1:0]      inRs1Data,
   input  logic [XLEN-1:0]      inRs2Data,
   input  logic [XLEN-1:0]      inImm,
   input  logic [4:0]           inRd,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [XLEN-1:0]      aluInput1,
   output logic [XLEN-1:0]      aluInput2,
   output logic [3:0]           aluControlAlu,
   output logic [4:0]           outRd,
   output logic                 outRegWrite,
   output logic                 outBranch,
`ifdef ALU_ISSUE_STATS_EN
   output logic [CNT_WIDTH-1:0] issueCount,
   output logic [CNT_WIDTH-1:0] illegalCount,
`endif
   output logic                 outIllegal
);

   typedef struct packed {
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      aluCtrl_t        ctl;
   } beat_t;

   beat_t inBeat, mainBeat, skidBeat;
   logic  mainValid, skidValid;
   logic  accIn, accOut;

   alu_op_decode #(.XLEN(XLEN)) uDecode (
      .opcode   (inOpcode),
      .funct3   (inFunct3),
      .funct7   (inFunct7),
      .rs1Data  (inRs1Data),
      .rs2Data  (inRs2Data),
      .imm      (inImm),
      .op1      (inBeat.op1),
      .op2      (inBeat.op2),
      .ctrl     (inBeat.ctl.ctrl),
      .regWrite (inBeat.ctl.regWrite),
      .branch   (inBeat.ctl.branch),
      .illegal  (inBeat.ctl.illegal)
   );
   assign inBeat.ctl.rd = inRd;

   // skidValid is a flop, so inReady is a registered output
   assign inReady = !skidValid;
   assign accIn   = inValid && inReady;
   assign accOut  = mainValid && outReady;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainValid <= 1'b0;
         skidValid <= 1'b0;
         mainBeat  <= '0;
         skidBeat  <= '0;
      end else if (flush) begin
         mainValid <= 1'b0;
         skidValid <= 1'b0;
      end else if (!mainValid || outReady) begin
         // Main register frees up this edge: refill from skid first to keep order.
         // accIn cannot be set while skid is occupied (inReady is low).
         if (skidValid) begin
            mainBeat  <= skidBeat;
            mainValid <= 1'b1;
            skidValid <= 1'b0;
         end else begin
            mainValid <= accIn;
            if (accIn) mainBeat <= inBeat;
         end
      end else if (accIn) begin
         // Output stalled but we advertised ready last cycle: park the beat in skid
         skidBeat  <= inBeat;
         skidValid <= 1'b1;
      end
   end

   assign outValid      = mainValid;
   assign aluInput1     = mainBeat.op1;
   assign aluInput2     = mainBeat.op2;
   assign aluControlAlu = mainBeat.ctl.ctrl;
   assign outRd         = mainBeat.ctl.rd;
   assign outRegWrite   = mainBeat.ctl.regWrite;
   assign outBranch     = mainBeat.ctl.branch;
   assign outIllegal    = mainBeat.ctl.illegal;

`ifdef ALU_ISSUE_STATS_EN
   // Count output-side transfers; flush does not clear these
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issueCount   <= '0;
         illegalCount <= '0;
      end else if (accOut) begin
         if (issueCount != '1) issueCount <= issueCount + 1'b1;
         if (mainBeat.ctl.illegal && illegalCount != '1) illegalCount <= illegalCount + 1'b1;
      end
   end
`else
   logic unusedAccOut;
   assign unusedAccOut = accOut;
`endif

endmodule
